// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and flag-bundle types shared by the ALU accumulator unit
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_ACC = 3'b110,
    OP_SHL = 3'b111
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational datapath: one shared add/sub plus logic, compare and shift
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   ext;
  logic             is_sub;
  logic             ovf_raw;
  logic [WIDTH-1:0] arith;

  // ACC reuses the adder with the accumulator as the left operand
  always_comb begin
    lhs     = (op_e'(op) == OP_ACC) ? acc_in : a;
    rhs     = (op_e'(op) == OP_ACC) ? a : b;
    is_sub  = (op_e'(op) == OP_SUB);
    ext     = is_sub ? ({1'b0, lhs} - {1'b0, rhs}) : ({1'b0, lhs} + {1'b0, rhs});
    if (is_sub) begin
      ovf_raw = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (ext[WIDTH-1] != lhs[WIDTH-1]);
    end else begin
      ovf_raw = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (ext[WIDTH-1] != lhs[WIDTH-1]);
    end
    // on overflow the true result has the sign of the left operand
    if (SAT && ovf_raw) begin
      arith = lhs[WIDTH-1] ? MIN_NEG : MAX_POS;
    end else begin
      arith = ext[WIDTH-1:0];
    end
  end

  always_comb begin
    res      = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_SUB, OP_ACC: begin
        res      = arith;
        carry    = ext[WIDTH];
        overflow = ovf_raw;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL:  res = a << b[SHW-1:0];
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_accum_unit.sv
// rtl/alu_accum_unit.sv - registered ALU with valid/ready handshake and running-sum register
module alu_accum_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] runsum,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] runsum_q, runsum_d;
  logic             out_valid_q, out_valid_d;
  flags_t           flags_q, flags_d;

  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] core_res;
  logic             core_carry;
  logic             core_ovf;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // a simultaneous clear is seen by the ACC as a zero accumulator
  assign acc_base = acc_clr ? '0 : runsum_q;

  alu_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .a        (a),
    .b        (b),
    .op       (op),
    .acc_in   (acc_base),
    .res      (core_res),
    .carry    (core_carry),
    .overflow (core_ovf)
  );

  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    runsum_d    = runsum_q;
    if (accept) begin
      result_d         = core_res;
      flags_d.carry    = core_carry;
      flags_d.zero     = (core_res == '0);
      flags_d.overflow = core_ovf;
      out_valid_d      = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && (op_e'(op) == OP_ACC)) begin
      runsum_d = core_res;
    end else if (acc_clr) begin
      runsum_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      runsum_q    <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      result_q    <= result_d;
      runsum_q    <= runsum_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign result    = result_q;
  assign runsum    = runsum_q;
  assign out_valid = out_valid_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_accum_unit.sv
// tb/tb_alu_accum_unit.sv - directed self-checking bench for alu_accum_unit
module tb_alu_accum_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        acc_clr;
  logic        out_ready;

  logic        in_ready, out_valid, carry, zero, overflow;
  logic [15:0] result, runsum;
  logic        s_in_ready, s_out_valid, s_carry, s_zero, s_overflow;
  logic [15:0] s_result, s_runsum;

  int n_checks = 0;
  int n_fail   = 0;

  alu_accum_unit #(.WIDTH(16), .SAT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .runsum(runsum),
    .carry(carry), .zero(zero), .overflow(overflow)
  );

  alu_accum_unit #(.WIDTH(16), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(s_out_valid),
    .out_ready(out_ready), .result(s_result), .runsum(s_runsum),
    .carry(s_carry), .zero(s_zero), .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] av,
                       input logic [15:0] bv, input logic clr);
    in_valid = v;
    op       = o;
    a        = av;
    b        = bv;
    acc_clr  = clr;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic c,
                         input logic z, input logic ov);
    chk16({tag, " result"}, result, r);
    chk1({tag, " carry"}, carry, c);
    chk1({tag, " zero"}, zero, z);
    chk1({tag, " overflow"}, overflow, ov);
    chk1({tag, " out_valid"}, out_valid, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
    #2;
    chk16("reset result", result, 16'h0);
    chk16("reset runsum", runsum, 16'h0);
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset carry", carry, 1'b0);
    chk1("reset zero", zero, 1'b0);
    chk1("reset overflow", overflow, 1'b0);
    chk1("reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive(1'b1, OP_ADD, 16'd3, 16'd4, 1'b0);
    cyc();
    chk_out("add 3+4", 16'd7, 1'b0, 1'b0, 1'b0);

    drive(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
    cyc();
    chk_out("add ovf wrap", 16'h8000, 1'b0, 1'b0, 1'b1);
    chk16("add ovf sat result", s_result, 16'h7FFF);
    chk1("add ovf sat overflow", s_overflow, 1'b1);

    drive(1'b1, OP_SUB, 16'h0000, 16'h0001, 1'b0);
    cyc();
    chk_out("sub 0-1", 16'hFFFF, 1'b1, 1'b0, 1'b0);

    drive(1'b1, OP_SUB, 16'h8000, 16'h0001, 1'b0);
    cyc();
    chk_out("sub neg ovf wrap", 16'h7FFF, 1'b0, 1'b0, 1'b1);
    chk16("sub neg ovf sat result", s_result, 16'h8000);

    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    cyc();
    chk_out("add carry out", 16'h0000, 1'b1, 1'b1, 1'b0);

    drive(1'b1, OP_ACC, 16'd1, 16'd0, 1'b0);
    cyc();
    chk16("acc1 runsum", runsum, 16'd1);
    drive(1'b1, OP_ACC, 16'd2, 16'd0, 1'b0);
    cyc();
    chk16("acc2 runsum", runsum, 16'd3);
    drive(1'b1, OP_ACC, 16'd3, 16'd0, 1'b0);
    cyc();
    chk16("acc3 runsum", runsum, 16'd6);
    chk16("acc3 result", result, 16'd6);
    drive(1'b1, OP_ACC, 16'd5, 16'd0, 1'b1);
    cyc();
    chk16("clr+acc runsum", runsum, 16'd5);
    chk_out("clr+acc", 16'd5, 1'b0, 1'b0, 1'b0);

    drive(1'b1, OP_AND, 16'h0F0F, 16'h00FF, 1'b0);
    cyc();
    chk_out("and", 16'h000F, 1'b0, 1'b0, 1'b0);
    chk16("non-acc keeps runsum", runsum, 16'd5);

    drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b1);
    cyc();
    chk16("clr alone runsum", runsum, 16'd0);
    chk1("idle out_valid", out_valid, 1'b0);

    drive(1'b1, OP_ADD, 16'd4, 16'd5, 1'b0);
    cyc();
    chk_out("add 4+5", 16'd9, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, OP_ACC, 16'd4, 16'd0, 1'b0);
    #1;
    chk1("stall in_ready", in_ready, 1'b0);
    cyc();
    chk_out("stall hold", 16'd9, 1'b0, 1'b0, 1'b0);
    chk16("stall runsum", runsum, 16'd0);
    cyc();
    chk16("stall hold2 result", result, 16'd9);
    out_ready = 1'b1;
    #1;
    chk1("release in_ready", in_ready, 1'b1);
    cyc();
    chk16("release acc result", result, 16'd4);
    chk16("release acc runsum", runsum, 16'd4);

    drive(1'b1, OP_XOR, 16'h00FF, 16'h00FF, 1'b0);
    cyc();
    chk_out("xor", 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, OP_SLT, 16'hFFFF, 16'h0001, 1'b0);
    cyc();
    chk_out("slt -1<1", 16'h0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_SLT, 16'h0001, 16'hFFFF, 1'b0);
    cyc();
    chk_out("slt 1<-1", 16'h0000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, OP_SHL, 16'h0001, 16'h0004, 1'b0);
    cyc();
    chk_out("shl", 16'h0010, 1'b0, 1'b0, 1'b0);
    drive(1'b1, OP_OR, 16'hA000, 16'h0005, 1'b0);
    cyc();
    chk_out("or", 16'hA005, 1'b0, 1'b0, 1'b0);

    drive(1'b1, OP_ACC, 16'd2, 16'd0, 1'b0);
    cyc();
    chk16("pre-reset runsum", runsum, 16'd6);
    chk1("pre-reset out_valid", out_valid, 1'b1);
    drive(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async out_valid", out_valid, 1'b0);
    chk16("async runsum", runsum, 16'd0);
    chk16("async result", result, 16'd0);
    chk1("async zero", zero, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_accum_unit.md
# alu_accum_unit

Parametrised, registered successor to the combinational 16-bit ALU. It accepts operand/opcode transactions over a valid/ready handshake and returns a registered result with status flags one cycle later. It also keeps a persistent running-sum register (`runsum`) that the ACC opcode updates. It sits between the operand sequencer and the result writeback path.

## Interface
- `WIDTH`, 16, operand/result width in bits (>= 4)
- `SAT`, 0, 1 = signed saturation for ADD/SUB/ACC; 0 = wrap-around

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand transaction present
- `in_ready`  out  1  unit can accept a transaction this cycle
- `a`, `b`  in  WIDTH  operands
- `op`  in  3  opcode (see Operation)
- `acc_clr`  in  1  clear `runsum`; independent of handshake
- `out_valid`  out  1  `result`/flags valid
- `out_ready`  in  1  downstream accepts result
- `result`  out  WIDTH  registered result
- `runsum`  out  WIDTH  running-sum register
- `carry`, `zero`, `overflow`  out  1 each  status flags registered with `result`

## Operation
- Opcodes:
  - 000 ADD = a+b
  - 001 SUB = a−b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: result = 1 if signed a < signed b, else 0
  - 110 ACC: result = runsum + a, and `runsum` ← result
  - 111 SHL: a << b[$clog2(WIDTH)-1:0]
- Transaction accepted when `in_valid && in_ready`.
- `carry`:
  - ADD/ACC: unsigned carry-out.
  - SUB: borrow (a < b unsigned).
  - All other ops: 0.
- `overflow`: signed overflow of ADD/SUB/ACC before any saturation; 0 for all other ops.
- `zero`: 1 iff the final registered `result` == 0.
- SAT=1, ADD/SUB/ACC on overflow: result clamps to 0111…1 (positive) or 1000…0 (negative). `overflow` still reports 1.
- `runsum` rules:
  - Changes only on an accepted ACC or on `acc_clr`.
  - `acc_clr` alone: `runsum` ← 0 at the next edge.
  - `acc_clr` together with an accepted ACC: the clear applies first, so `runsum` ← a and result = a (flags computed on 0 + a).
  - Accepted non-ACC op: `runsum` unchanged.
- Reset values: `result`=0, `runsum`=0, `out_valid`=0, `carry`=`zero`=`overflow`=0.
- Reset asserted mid-transaction: the pending result is discarded, with no partial output.

## Timing
- Latency 1: a transaction accepted at edge N appears with `out_valid`=1 after edge N.
- `in_ready` = `!out_valid || out_ready` (combinational). With `out_ready` tied high, throughput is 1 transaction per cycle.
- Backpressure (`out_valid && !out_ready`):
  - `result`, flags and `out_valid` hold stable.
  - `in_ready`=0.
  - No transaction is accepted, so `runsum` is not updated by ACC.
- `acc_clr` is still honoured while stalled.
- `out_valid` falls after an edge with `out_ready`=1 and no new accept.
- `runsum` output reflects the register, i.e. the post-edge value. It updates on the same edge as the ACC `result`.
- Back-to-back ACC: the second ACC uses the `runsum` written by the first, with no hazard.

## Structure
- Shared package `alu_pkg`: opcode constants (ADD…SHL) as a 3-bit enum, plus the flag-bundle typedef.
- Sub-module `alu_core`:
  - Purely combinational.
  - Inputs: `a`, `b`, `op`, accumulator operand. Outputs: raw result, carry, overflow.
  - Parameters: `WIDTH`, `SAT`.
- Top level holds the handshake, the output register, the `runsum` register and the clear-priority logic.

## Test plan
- Reset, then ADD with a=3, b=4 and `out_ready`=1 → next cycle result=7, carry=0, zero=0, overflow=0, `out_valid`=1.
- WIDTH=16, SAT=0, ADD a=0x7FFF, b=1 → result=0x8000, overflow=1. Repeat with SAT=1 → result=0x7FFF, overflow=1. SUB a=0, b=1 → 0xFFFF, carry=1.
- ACC with a=1, then 2, then 3 on consecutive cycles → `runsum` reads 1, 3, 6. Next cycle assert `acc_clr` together with ACC a=5 → `runsum`=5, result=5.
- Hold `out_ready`=0 after an ADD with result 9 and keep `in_valid`=1 with ACC a=4 → `in_ready`=0, result stays 9, `runsum` unchanged. Release `out_ready` → the ACC is accepted on that edge.
- XOR a=0x00FF, b=0x00FF → result=0, zero=1. SLT a=0xFFFF, b=1 → result=1. SHL a=1, b=4 → 0x0010.
- Assert `rst_n` low asynchronously with `out_valid`=1 and `runsum`=6 → all outputs go to 0 immediately, without waiting for a clock edge.
